// File: rtl/weight_mem_loader.sv
// weight_mem_loader: streams weight words into one neuron's weight memory of the served layer.
// Optional XOR checksum of the loaded words is built when WEIGHT_LOAD_CHECKSUM_EN is defined.
module weight_mem_loader #(
  parameter int layerNo      = 1,
  parameter int numNeurons   = 28,
  parameter int numWeight    = 784,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic [7:0]            cfg_layer,
  input  logic [7:0]            cfg_neuron,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [dataWidth-1:0]  s_data,
  input  logic                  s_last,
  output logic [numNeurons-1:0] wen,
  output logic [addressWidth:0] waddr,
  output logic [dataWidth-1:0]  win,
  output logic                  busy,
  output logic                  done,
  output logic                  err_cfg,
  output logic                  err_len,
  output logic [dataWidth-1:0]  checksum
);

  localparam int CW = addressWidth + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(numWeight - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [numNeurons-1:0] sel_q, sel_d;
  logic [CW-1:0]         count_q, count_d;
  logic [numNeurons-1:0] wen_q, wen_d;
  logic [CW-1:0]         waddr_q, waddr_d;
  logic [dataWidth-1:0]  win_q, win_d;
  logic                  s_ready_q, s_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_cfg_q, err_cfg_d;
  logic                  err_len_q, err_len_d;

  logic                  cfg_ok_s;
  logic                  start_ok_s;
  logic                  hs_s;
  logic                  at_last_s;
  logic                  final_word_s;
  logic [numNeurons-1:0] onehot_s;

  // Start qualification, handshake and final-word detection.
  always_comb begin
    cfg_ok_s     = (cfg_layer == 8'(layerNo)) && (cfg_neuron < 8'(numNeurons));
    start_ok_s   = (state_q == S_IDLE) && cfg_start && cfg_ok_s;
    hs_s         = s_valid && s_ready_q;
    at_last_s    = (count_q == LAST_IDX);
    final_word_s = s_last || at_last_s;
    onehot_s     = '0;
    for (int i = 0; i < numNeurons; i++) begin
      onehot_s[i] = (cfg_neuron == 8'(i));
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok_s) state_d = S_LOAD;
        else            state_d = S_IDLE;
      end
      S_LOAD: begin
        if (hs_s && final_word_s) state_d = S_DONE;
        else                      state_d = S_LOAD;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; status flags follow the next state so they are registered.
  always_comb begin
    sel_d     = sel_q;
    count_d   = count_q;
    wen_d     = '0;
    waddr_d   = waddr_q;
    win_d     = win_q;
    err_cfg_d = 1'b0;
    err_len_d = err_len_q;
    s_ready_d = (state_d == S_LOAD);
    busy_d    = (state_d == S_LOAD);
    done_d    = (state_d == S_DONE);

    if ((state_q == S_IDLE) && cfg_start) begin
      if (cfg_ok_s) begin
        sel_d     = onehot_s;
        count_d   = '0;
        err_len_d = 1'b0;
      end else begin
        err_cfg_d = 1'b1;
      end
    end else begin
      err_cfg_d = 1'b0;
    end

    // Count holds on the final word, so waddr can never pass numWeight-1.
    if (hs_s) begin
      wen_d   = sel_q;
      waddr_d = count_q;
      win_d   = s_data;
      if (final_word_s) count_d = count_q;
      else              count_d = count_q + CW'(1);
      if (s_last != at_last_s) err_len_d = 1'b1;
      else                     err_len_d = err_len_q;
    end else begin
      wen_d = '0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sel_q     <= '0;
      count_q   <= '0;
      wen_q     <= '0;
      waddr_q   <= '0;
      win_q     <= '0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_cfg_q <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      count_q   <= count_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      win_q     <= win_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_cfg_q <= err_cfg_d;
      err_len_q <= err_len_d;
    end
  end

  assign s_ready = s_ready_q;
  assign wen     = wen_q;
  assign waddr   = waddr_q;
  assign win     = win_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err_cfg = err_cfg_q;
  assign err_len = err_len_q;

`ifdef WEIGHT_LOAD_CHECKSUM_EN
  function automatic logic [dataWidth-1:0] csum_next(input logic [dataWidth-1:0] acc,
                                                      input logic [dataWidth-1:0] word);
    return acc ^ word;
  endfunction

  logic [dataWidth-1:0] csum_q, csum_d;

  // Checksum restarts on an accepted start and folds in every accepted word.
  always_comb begin
    csum_d = csum_q;
    if (start_ok_s)  csum_d = '0;
    else if (hs_s)   csum_d = csum_next(csum_q, s_data);
    else             csum_d = csum_q;
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_weight_mem_loader.sv
// Directed bench for weight_mem_loader: scoreboard of expected writes checked by a negedge monitor.
module tb_weight_mem_loader;
  localparam int NN = 28;
  localparam int NW = 784;
  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start;
  logic [7:0]    cfg_layer;
  logic [7:0]    cfg_neuron;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic [NN-1:0] wen;
  logic [AW:0]   waddr;
  logic [DW-1:0] win;
  logic          busy;
  logic          done;
  logic          err_cfg;
  logic          err_len;
  logic [DW-1:0] checksum;

  always #5 clk = ~clk;

  weight_mem_loader dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .wen(wen), .waddr(waddr), .win(win), .busy(busy), .done(done),
    .err_cfg(err_cfg), .err_len(err_len), .checksum(checksum)
  );

  typedef struct packed {
    logic [NN-1:0] wen;
    logic [AW:0]   addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  int            tests = 0;
  int            fails = 0;
  bit            mon_en = 1'b0;
  logic [NN-1:0] cur_sel;
  int            cur_addr;
  logic [DW-1:0] exp_csum;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every write on the bus must match the oldest expected write.
  always @(negedge clk) begin : mon
    wr_t e;
    if (mon_en && (wen !== '0)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(wen), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("write_wen", 32'(wen), 32'(e.wen));
        check("write_addr", 32'(waddr), 32'(e.addr));
        check("write_data", 32'(win), 32'(e.data));
      end
    end
  end

  task automatic do_start(input int layer, input int neuron, input bit ok);
    cfg_start  = 1'b1;
    cfg_layer  = 8'(layer);
    cfg_neuron = 8'(neuron);
    @(negedge clk);
    cfg_start = 1'b0;
    if (ok) begin
      check("start_busy", 32'(busy), 32'd1);
      check("start_ready", 32'(s_ready), 32'd1);
      check("start_errlen_clear", 32'(err_len), 32'd0);
      check("start_no_errcfg", 32'(err_cfg), 32'd0);
      cur_sel  = NN'(1) << neuron;
      cur_addr = 0;
      exp_csum = '0;
    end else begin
      check("reject_errcfg", 32'(err_cfg), 32'd1);
      check("reject_busy", 32'(busy), 32'd0);
      check("reject_ready", 32'(s_ready), 32'd0);
      @(negedge clk);
      check("reject_errcfg_pulse", 32'(err_cfg), 32'd0);
      check("reject_busy_idle", 32'(busy), 32'd0);
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input bit last, input bit exp_acc);
    wr_t e;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    check("s_ready", 32'(s_ready), 32'(exp_acc));
    if (exp_acc) begin
      e.wen  = cur_sel;
      e.addr = (AW+1)'(cur_addr);
      e.data = d;
      exp_q.push_back(e);
      cur_addr++;
      exp_csum = exp_csum ^ d;
    end
    @(negedge clk);
  endtask

  task automatic end_load(input bit exp_err);
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy_off", 32'(busy), 32'd0);
    check("done_ready_off", 32'(s_ready), 32'd0);
    check("done_err_len", 32'(err_len), 32'(exp_err));
`ifdef WEIGHT_LOAD_CHECKSUM_EN
    check("checksum", 32'(checksum), 32'(exp_csum));
`else
    check("checksum_tied", 32'(checksum), 32'd0);
`endif
    @(negedge clk);
    check("done_single", 32'(done), 32'd0);
    check("err_len_sticky", 32'(err_len), 32'(exp_err));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst        = 1'b0;
    cfg_start  = 1'b0;
    cfg_layer  = 8'd0;
    cfg_neuron = 8'd0;
    s_valid    = 1'b0;
    s_data     = '0;
    s_last     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wen", 32'(wen), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_win", 32'(win), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_errs", 32'({err_cfg, err_len}), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    rst    = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Full load, neuron 3, data equals address, s_last on the final word.
    do_start(1, 3, 1'b1);
    for (int i = 0; i < NW; i++) send(DW'(i), (i == NW - 1), 1'b1);
    end_load(1'b0);

    // Rejected starts: wrong layer, neuron just out of range.
    do_start(2, 0, 1'b0);
    do_start(1, 28, 1'b0);
    check("reject_no_busy", 32'(busy), 32'd0);

    // Valid toggled every other cycle, early s_last on word #10.
    do_start(1, 5, 1'b1);
    for (int i = 0; i < 10; i++) begin
      send(DW'(16'h0200 + i), (i == 9), 1'b1);
      if (i != 9) begin
        s_valid = 1'b0;
        check("gap_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
      end
    end
    end_load(1'b1);

    // Next valid start clears err_len; top neuron index; early s_last again.
    do_start(1, 27, 1'b1);
    for (int i = 0; i < 10; i++) send(DW'(16'h1000 + i), (i == 9), 1'b1);
    end_load(1'b1);

    // Full length without s_last, then one extra word that must be refused.
    do_start(1, 0, 1'b1);
    for (int i = 0; i < NW; i++) send(DW'(16'h4000 + i), 1'b0, 1'b1);
    check("nolast_done", 32'(done), 32'd1);
    check("nolast_err_len", 32'(err_len), 32'd1);
    send(16'hDEAD, 1'b0, 1'b0);
    s_valid = 1'b0;
    check("extra_done_off", 32'(done), 32'd0);
    check("extra_err_len", 32'(err_len), 32'd1);
    repeat (2) @(negedge clk);
    check("extra_not_written", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a load at word #100.
    do_start(1, 7, 1'b1);
    for (int i = 0; i < 100; i++) send(DW'(16'h7000 + i), 1'b0, 1'b1);
    rst     = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'h7064;
    @(negedge clk);
    check("midrst_wen", 32'(wen), 32'd0);
    check("midrst_waddr", 32'(waddr), 32'd0);
    check("midrst_win", 32'(win), 32'd0);
    check("midrst_flags", 32'({s_ready, busy, done, err_cfg, err_len}), 32'd0);
    check("midrst_checksum", 32'(checksum), 32'd0);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("postrst_ready", 32'(s_ready), 32'd0);
      check("postrst_busy", 32'(busy), 32'd0);
    end
    s_valid = 1'b0;
    check("postrst_queue", 32'(exp_q.size()), 32'd0);

    // Two-word load with complementary patterns.
    do_start(1, 2, 1'b1);
    send(16'hA5A5, 1'b0, 1'b1);
    send(16'h5A5A, 1'b1, 1'b1);
`ifdef WEIGHT_LOAD_CHECKSUM_EN
    check("checksum_a5_5a", 32'(checksum), 32'h0000FFFF);
`endif
    end_load(1'b1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
